// File: rtl/adc_disp_pkg.sv
// Shared display constants, 7-segment code table and prescaler sizing helper
// for the ADC sample display path.
package adc_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off for every digit.
  function automatic logic [7:0] seg_of(input logic [3:0] bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic int presc_w(input int clk_hz, input int dig_hz);
    int w;
    w = $clog2(clk_hz / dig_hz);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start in IDLE, DATA_W add-3/shift cycles, one DONE cycle.
// busy covers SHIFT and DONE so a new start is only taken once back in IDLE.
module bin2bcd_seq
  import adc_disp_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              CLK_IN1,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_e       state_q;
  logic [15:0]       bcd_q;
  logic [DATA_W-1:0] bin_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      state_q <= CONV_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start) begin
            state_q <= CONV_SHIFT;
            bcd_q   <= '0;
            bin_q   <= bin;
            cnt_q   <= '0;
          end
        end
        CONV_SHIFT: begin
          // Binary MSB shifts into the adjusted BCD field.
          {bcd_q, bin_q} <= {adj[14:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= CONV_DONE;
        end
        CONV_DONE: state_q <= CONV_IDLE;
        default:   state_q <= CONV_IDLE;
      endcase
    end
  end

  assign busy = (state_q != CONV_IDLE);
  assign done = (state_q == CONV_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/adc_sample_display.sv
// Averages 2^AVG_LOG2 ADC samples per channel, converts to BCD and scans a 4-digit display.
// Display/leds update DATA_W+2 cycles after the final sample; that sample stalls while the converter is busy.
module adc_sample_display
  import adc_disp_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIG_HZ   = 4000
) (
  input  logic              CLK_IN1,
  input  logic              RESET,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  input  logic [2:0]        chan_i,
  output logic [3:0]        an,
  output logic [7:0]        sseg,
  output logic [7:0]        leds
);

  localparam int                 ACC_W      = DATA_W + AVG_LOG2;
  localparam int                 CNT_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam int                 PRESC_W    = presc_w(CLK_HZ, DIG_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ / DIG_HZ - 1);

  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         chan_q;
  logic               live_q;
  logic               start_q;
  logic [DATA_W-1:0]  avg_q;
  logic [15:0]        digits_q;
  logic [7:0]         leds_q;
  logic [1:0]         idx_q;
  logic [PRESC_W-1:0] presc_q;
  logic [3:0]         an_q;
  logic [7:0]         sseg_q;

  logic               chan_chg;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt_base;
  logic               accept;
  logic               final_smp;
  logic               conv_busy;
  logic               conv_done;
  logic [15:0]        conv_bcd;
  logic               blank1, blank2, blank3;
  logic [7:0]         scan_code;

  // A channel change discards the partial sum; a sample taken that cycle starts the new one.
  assign chan_chg  = (chan_i != chan_q);
  assign acc_base  = chan_chg ? '0 : acc_q;
  assign cnt_base  = chan_chg ? '0 : cnt_q;
  assign acc_sum   = acc_base + ACC_W'(sample_i);

  // start_q counts as busy so the converter is always IDLE when start_q is presented.
  assign sample_ready_o = live_q && !((cnt_q == CNT_LAST) && (conv_busy || start_q));
  assign accept         = sample_valid_i && sample_ready_o;
  assign final_smp      = accept && (cnt_base == CNT_LAST);

  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      chan_q   <= '0;
      live_q   <= 1'b0;
      start_q  <= 1'b0;
      avg_q    <= '0;
      digits_q <= '0;
      leds_q   <= '0;
    end else begin
      live_q  <= 1'b1;
      chan_q  <= chan_i;
      start_q <= final_smp;
      if (final_smp) begin
        acc_q <= '0;
        cnt_q <= '0;
        avg_q <= DATA_W'(acc_sum >> AVG_LOG2);
      end else if (accept) begin
        acc_q <= acc_sum;
        cnt_q <= cnt_base + CNT_W'(1);
      end else if (chan_chg) begin
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (conv_done) begin
        digits_q <= conv_bcd;
        leds_q   <= avg_q[DATA_W-1 -: 8];
      end
    end
  end

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
    .CLK_IN1 (CLK_IN1),
    .RESET   (RESET),
    .start   (start_q),
    .bin     (avg_q),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  assign blank3 = (digits_q[15:12] == 4'd0);
  assign blank2 = blank3 && (digits_q[11:8] == 4'd0);
  assign blank1 = blank2 && (digits_q[7:4] == 4'd0);

  always_comb begin
    scan_code = SEG_BLANK;
    case (idx_q)
      2'd0:    scan_code = seg_of(digits_q[3:0]);
      2'd1:    if (!blank1) scan_code = seg_of(digits_q[7:4]);
      2'd2:    if (!blank2) scan_code = seg_of(digits_q[11:8]);
      default: if (!blank3) scan_code = seg_of(digits_q[15:12]);
    endcase
  end

  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= AN_OFF;
      sseg_q  <= SEG_BLANK;
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
      // Enable and segments register together from the same index.
      an_q   <= ~(4'b0001 << idx_q);
      sseg_q <= scan_code;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_adc_sample_display.sv
// Directed + randomized bench for adc_sample_display (DATA_W=12, AVG_LOG2=2, 8-cycle digit tick);
// expected averages and digit codes come from a list-based model and decimal arithmetic.
module tb_adc_sample_display;

  logic        clk;
  logic        rst;
  logic [11:0] sample;
  logic        valid;
  logic        ready;
  logic [2:0]  chan;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [7:0]  leds;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cur_chan;
  int          acc_list[$];
  int          pend_avg;
  bit          pend;
  logic [7:0]  shown_leds;
  logic [7:0]  codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  adc_sample_display #(
    .DATA_W   (12),
    .AVG_LOG2 (2),
    .CLK_HZ   (8),
    .DIG_HZ   (1)
  ) dut (
    .CLK_IN1        (clk),
    .RESET          (rst),
    .sample_i       (sample),
    .sample_valid_i (valid),
    .sample_ready_o (ready),
    .chan_i         (chan),
    .an             (an),
    .sseg           (sseg),
    .leds           (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_set_chan(input int c);
    if (c != cur_chan) begin
      acc_list.delete();
      cur_chan = c;
    end
  endfunction

  function automatic void model_push(input int s);
    int sum;
    acc_list.push_back(s);
    if (acc_list.size() == 4) begin
      sum = 0;
      foreach (acc_list[k]) sum += acc_list[k];
      pend_avg = sum / 4;
      pend     = 1'b1;
      acc_list.delete();
    end
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (i > 0 && v < p) return 8'hFF;
    return codes[(v / p) % 10];
  endfunction

  task automatic send(input int s, input int c);
    int n;
    @(negedge clk);
    chan  = 3'(c);
    model_set_chan(c);
    sample = 12'(s);
    valid  = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    model_push(s);
  endtask

  task automatic scan_check(input int v);
    logic [3:0] pat;
    int n;
    for (int i = 0; i < 4; i++) begin
      pat = ~(4'b0001 << i);
      n = 0;
      @(negedge clk);
      while (an !== pat && n < 64) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("scan_an%0d", i), an, pat);
      check($sformatf("sseg_dig%0d_val%0d", i, v), sseg, exp_seg(v, i));
    end
  endtask

  // Called right after the accepting edge of a final sample.
  task automatic finalize(input int avg);
    logic [11:0] a;
    a = 12'(avg);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("leds_before_done", leds, shown_leds);
    @(posedge clk);
    @(negedge clk);
    check("leds_at_latency", leds, a[11:4]);
    shown_leds = a[11:4];
    pend = 1'b0;
    repeat (2) @(posedge clk);
    scan_check(avg);
  endtask

  task automatic send_chk(input int s, input int c);
    send(s, c);
    if (pend) finalize(pend_avg);
  endtask

  initial begin
    int ca, cb, k, since, stalls, n;
    bit prev_rdy;

    // 1. reset values and first cycle after release
    rst = 1'b1; valid = 1'b0; sample = '0; chan = 3'd2;
    cur_chan = 2; pend = 1'b0; shown_leds = 8'h00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_sseg", sseg, 8'hFF);
    check("rst_leds", leds, 8'h00);
    check("rst_ready", ready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_an", an, 4'hE);
    check("rel_sseg", sseg, 8'hC0);
    check("rel_ready", ready, 1'b1);

    // 2. average 250 with exact latency
    send_chk(100, 2); send_chk(200, 2); send_chk(300, 2); send_chk(400, 2);

    // 3. full scale
    for (int j = 0; j < 4; j++) send_chk(4095, 2);

    // 4. partial sum on chan 2 is discarded by the switch to chan 5
    send_chk($urandom_range(0, 4095), 2);
    send_chk($urandom_range(0, 4095), 2);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("leds_hold_partial", leds, shown_leds);
    for (int j = 0; j < 4; j++) send_chk(8, 5);

    // randomized channels and partial groups
    for (int r = 0; r < 6; r++) begin
      ca = $urandom_range(0, 7);
      k  = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) send_chk($urandom_range(0, 4095), ca);
      cb = $urandom_range(0, 7);
      for (int j = 0; j < 4; j++) send_chk($urandom_range(0, 4095), cb);
    end

    // 5. valid held with constant 1000: 4 accepts between stalls
    @(negedge clk);
    chan = 3'(cur_chan);
    sample = 12'd1000;
    valid = 1'b1;
    prev_rdy = 1'b1; since = 0; stalls = 0;
    for (int c = 0; c < 90; c++) begin
      if (ready) begin
        since++;
        model_push(1000);
      end else if (prev_rdy) begin
        stalls++;
        if (stalls > 1) check("accepts_per_update", since, 4);
        since = 0;
      end
      prev_rdy = ready;
      @(negedge clk);
    end
    valid = 1'b0;
    check("stalls_seen", 32'(stalls >= 3), 1);
    pend = 1'b0;
    shown_leds = 8'h3E;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("leds_1000", leds, 8'h3E);
    scan_check(1000);

    // 6. reset during SHIFT
    n = 0;
    while (!pend && n < 8) begin
      send($urandom_range(0, 4095), 5);
      n++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_an", an, 4'hF);
    check("midrst_sseg", sseg, 8'hFF);
    check("midrst_leds", leds, 8'h00);
    check("midrst_ready", ready, 1'b0);
    acc_list.delete();
    pend = 1'b0;
    shown_leds = 8'h00;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrel_an", an, 4'hE);
    check("midrel_sseg", sseg, 8'hC0);
    scan_check(0);
    for (int j = 0; j < 4; j++) send_chk($urandom_range(0, 4095), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
